mem_access_arbiter: RTL and testbench

- Owns the single shared main-memory port and shares it between the instruction-side miss handler (fetch path) and the data-side miss handler.
- Sequences 8-word block fills and single-word write-through stores.
- Sits between the I/D cache controllers and the multi-cycle main memory.
- Fetch stalls on i_miss_req until it sees i_fill_done.

---
 rtl/mem_access_arbiter_pkg.sv | 33 +++
 rtl/mem_access_arbiter_if.sv | 55 +++++
 rtl/mem_access_arbiter_fill_seq.sv | 69 ++++++
 rtl/mem_access_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
// Block geometry here must agree with the 3-bit fill_word ports.
package mem_access_arbiter_pkg;

  localparam int MEM_LATENCY     = 4;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFF_W     = $clog2(2 * WORDS_PER_BLOCK);
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Round-robin between the two miss sides; a lone requester always wins.
  function automatic owner_e pick_owner(input logic i_req, input logic d_req,
                                        input owner_e last_owner);
    if (i_req && d_req) begin
      return (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      return OWN_D;
    end
    return OWN_I;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of the cache-side request/fill signals and the main-memory port.
// slave is the arbiter's view; master is the caches-plus-memory view.
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  import mem_access_arbiter_pkg::*;

  logic                  i_miss_req;
  logic [ADDR_W-1:0]     i_miss_addr;
  logic                  i_fill_valid;
  logic [DATA_W-1:0]     i_fill_data;
  logic [WORD_IDX_W-1:0] i_fill_word;
  logic                  i_fill_done;

  logic                  d_miss_req;
  logic [ADDR_W-1:0]     d_miss_addr;
  logic                  d_fill_valid;
  logic [DATA_W-1:0]     d_fill_data;
  logic [WORD_IDX_W-1:0] d_fill_word;
  logic                  d_fill_done;

  logic                  d_wr_req;
  logic [ADDR_W-1:0]     d_wr_addr;
  logic [DATA_W-1:0]     d_wr_data;
  logic                  d_wr_ack;

  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_data_in;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [DATA_W-1:0]     mem_data_out;
  logic                  mem_data_valid;

  logic                  busy;

  modport slave (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_out, mem_data_valid,
    output i_fill_valid, i_fill_data, i_fill_word, i_fill_done,
    output d_fill_valid, d_fill_data, d_fill_word, d_fill_done,
    output d_wr_ack, mem_addr, mem_data_in, mem_enable, mem_wr, busy
  );

  modport master (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_out, mem_data_valid,
    input  i_fill_valid, i_fill_data, i_fill_word, i_fill_done,
    input  d_fill_valid, d_fill_data, d_fill_word, d_fill_done,
    input  d_wr_ack, mem_addr, mem_data_in, mem_enable, mem_wr, busy
  );

endinterface

// File: rtl/mem_access_arbiter_fill_seq.sv
// Block-fill sequencer: latches the block base, issues one read per cycle and
// counts returning words independently, since reads and returns overlap.
module mem_fill_sequencer
  import mem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     miss_addr_i,
  input  logic                  active_i,
  input  logic                  data_valid_i,
  output logic [ADDR_W-1:0]     issue_addr_o,
  output logic [WORD_IDX_W-1:0] recv_cnt_o,
  output logic                  issue_done_o,
  output logic                  last_word_o
);

  localparam logic [ADDR_W-1:0]     OFF_MASK   = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [WORD_IDX_W:0]   ISSUE_END  = (WORD_IDX_W + 1)'(WORDS_PER_BLOCK);
  localparam logic [WORD_IDX_W-1:0] RECV_LAST  = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

  logic [ADDR_W-1:0]     base_q, base_d;
  logic [WORD_IDX_W:0]   issue_cnt_q, issue_cnt_d;
  logic [WORD_IDX_W-1:0] recv_cnt_q, recv_cnt_d;

  assign issue_done_o = (issue_cnt_q == ISSUE_END);
  assign last_word_o  = (recv_cnt_q == RECV_LAST);
  assign recv_cnt_o   = recv_cnt_q;
  // Base low bits are always zero, so OR-ing the word offset is an add.
  assign issue_addr_o = base_q | ADDR_W'({issue_cnt_q[WORD_IDX_W-1:0], 1'b0});

  always_comb begin
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    if (start_i) begin
      base_d      = miss_addr_i & ~OFF_MASK;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else if (active_i) begin
      if (!issue_done_o) begin
        issue_cnt_d = issue_cnt_q + 1'b1;
      end
      if (data_valid_i) begin
        if (last_word_o) begin
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end else begin
          recv_cnt_d = recv_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the single main-memory port between I-side and D-side block fills
// and D-side write-through stores; stores take priority, misses round-robin.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  owner_e     grant_owner;
  logic       fill_start;
  logic       fill_active;

  logic [ADDR_W-1:0]     grant_addr;
  logic [ADDR_W-1:0]     issue_addr;
  logic [WORD_IDX_W-1:0] recv_cnt;
  logic                  issue_done;
  logic                  last_word;

  logic                  mem_enable_c;
  logic                  mem_wr_c;
  logic [ADDR_W-1:0]     mem_addr_c;
  logic [DATA_W-1:0]     mem_wdata_c;
  logic                  wr_ack_c;

  logic [1:0]            side_sel;
  logic [1:0]            side_valid;
  logic [1:0]            side_done;
  logic [DATA_W-1:0]     side_data [2];
  logic [WORD_IDX_W-1:0] side_word [2];

  assign grant_owner = pick_owner(bus.i_miss_req, bus.d_miss_req, last_owner_q);
  assign grant_addr  = (grant_owner == OWN_D) ? bus.d_miss_addr : bus.i_miss_addr;
  assign fill_active = (state_q == FILL_I) || (state_q == FILL_D);

  mem_fill_sequencer #(
    .ADDR_W (ADDR_W)
  ) u_fill_seq (
    .clk          (clk),
    .rst          (rst),
    .start_i      (fill_start),
    .miss_addr_i  (grant_addr),
    .active_i     (fill_active),
    .data_valid_i (bus.mem_data_valid),
    .issue_addr_o (issue_addr),
    .recv_cnt_o   (recv_cnt),
    .issue_done_o (issue_done),
    .last_word_o  (last_word)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    fill_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_wr_req) begin
          state_d = WRITE;
        end else if (bus.i_miss_req || bus.d_miss_req) begin
          fill_start   = 1'b1;
          last_owner_d = grant_owner;
          state_d      = (grant_owner == OWN_D) ? FILL_D : FILL_I;
        end
      end
      WRITE: state_d = IDLE;
      // A fill ignores request deassertion: issued reads cannot be recalled.
      FILL_I, FILL_D: begin
        if (bus.mem_data_valid && last_word) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_enable_c = 1'b0;
    mem_wr_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    wr_ack_c     = 1'b0;
    if (state_q == WRITE) begin
      mem_enable_c = 1'b1;
      mem_wr_c     = 1'b1;
      mem_addr_c   = bus.d_wr_addr;
      mem_wdata_c  = bus.d_wr_data;
      wr_ack_c     = 1'b1;
    end else if (fill_active && !issue_done) begin
      mem_enable_c = 1'b1;
      mem_addr_c   = issue_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_D;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Index 0 is the I side, 1 the D side; valid data outside a fill is dropped.
  assign side_sel = {state_q == FILL_D, state_q == FILL_I};

  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    assign side_valid[gi] = side_sel[gi] && bus.mem_data_valid;
    assign side_done[gi]  = side_valid[gi] && last_word;
    assign side_data[gi]  = side_valid[gi] ? bus.mem_data_out : '0;
    assign side_word[gi]  = side_valid[gi] ? recv_cnt : '0;
  end

  assign bus.i_fill_valid = side_valid[0];
  assign bus.i_fill_data  = side_data[0];
  assign bus.i_fill_word  = side_word[0];
  assign bus.i_fill_done  = side_done[0];
  assign bus.d_fill_valid = side_valid[1];
  assign bus.d_fill_data  = side_data[1];
  assign bus.d_fill_word  = side_word[1];
  assign bus.d_fill_done  = side_done[1];

  assign bus.d_wr_ack     = wr_ack_c;
  assign bus.mem_enable   = mem_enable_c;
  assign bus.mem_wr       = mem_wr_c;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_data_in  = mem_wdata_c;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: latency-accurate memory model, transaction-level
// reference model checked every cycle, directed scenarios and random traffic.
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[6:0], a[15:7]} ^ 16'h3C96;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit side_d, input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = side_d ? bus.d_fill_done : bus.i_fill_done;
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  // Memory: a read seen in cycle c returns its data in cycle c+MEM_LATENCY.
  initial begin
    logic              pv [MEM_LATENCY];
    logic [15:0]       pa [MEM_LATENCY];
    logic              iss_v;
    logic [15:0]       iss_a;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    bus.mem_data_valid = 1'b0;
    bus.mem_data_out   = '0;
    forever begin
      @(negedge clk);
      iss_v = bus.mem_enable && !bus.mem_wr;
      iss_a = bus.mem_addr;
      @(posedge clk);
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = iss_v;
      pa[0] = iss_a;
      #1;
      bus.mem_data_valid = pv[MEM_LATENCY-1];
      bus.mem_data_out   = pv[MEM_LATENCY-1] ? mem_f(pa[MEM_LATENCY-1]) : 16'($urandom);
    end
  end

  // Reference model: one transaction at a time, judged from the request rules.
  initial begin
    int          mode;
    bit          own_d;
    bit          last_d;
    bit          pick_d;
    logic [15:0] base;
    int          k;
    int          recv;
    logic        e_en, e_wr, e_ack, e_busy;
    logic [15:0] e_addr, e_wdata;
    logic        e_v, e_done;
    logic [15:0] e_data;
    logic [2:0]  e_word;
    mode = 0; last_d = 1'b1; own_d = 1'b0; base = '0; k = 0; recv = 0;
    forever begin
      @(negedge clk);
      e_en = 0; e_wr = 0; e_ack = 0; e_busy = 0; e_addr = '0; e_wdata = '0;
      e_v = 0; e_done = 0; e_data = '0; e_word = '0;
      if (rst) begin
        mode = 0;
        last_d = 1'b1;
      end else if (mode == 1) begin
        e_en = 1; e_wr = 1; e_ack = 1; e_busy = 1;
        e_addr = bus.d_wr_addr; e_wdata = bus.d_wr_data;
        mode = 0;
      end else if (mode == 2) begin
        e_busy = 1;
        if (k < WORDS_PER_BLOCK) begin
          e_en = 1;
          e_addr = base + 16'(2 * k);
          k++;
        end
        if (bus.mem_data_valid) begin
          e_v = 1;
          e_data = mem_f(base + 16'(2 * recv));
          e_word = 3'(recv);
          e_done = (recv == WORDS_PER_BLOCK - 1);
          if (e_done) mode = 0;
          else recv++;
        end
      end else begin
        if (bus.d_wr_req) begin
          mode = 1;
        end else if (bus.i_miss_req || bus.d_miss_req) begin
          pick_d = (bus.i_miss_req && bus.d_miss_req) ? !last_d : bus.d_miss_req;
          own_d  = pick_d;
          last_d = pick_d;
          base   = (pick_d ? bus.d_miss_addr : bus.i_miss_addr) & 16'hFFF0;
          k = 0; recv = 0; mode = 2;
        end
      end
      chk("mem_port", {bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in},
          {e_en, e_wr, e_addr, e_wdata});
      chk("i_fill", {bus.i_fill_valid, bus.i_fill_data, bus.i_fill_word, bus.i_fill_done},
          own_d ? 21'd0 : {e_v, e_data, e_word, e_done});
      chk("d_fill", {bus.d_fill_valid, bus.d_fill_data, bus.d_fill_word, bus.d_fill_done},
          own_d ? {e_v, e_data, e_word, e_done} : 21'd0);
      chk("ack_busy", {bus.d_wr_ack, bus.busy}, {e_ack, e_busy});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.i_miss_req = 0; bus.i_miss_addr = '0;
    bus.d_miss_req = 0; bus.d_miss_addr = '0;
    bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    int words, dones, stale;
    bit si, sd, sa;
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_en", bus.mem_enable, 0);
    chk("rst_ack", bus.d_wr_ack, 0);
    nxt();
    rst = 1'b0;

    // I miss alone: addresses 0x1230..0x123E, done in cycle 12 with word 7.
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h1236;
    nxt();
    @(negedge clk);
    chk("t1_addr_first", {bus.mem_enable, bus.mem_addr}, {1'b1, 16'h1230});
    repeat (7) nxt();
    @(negedge clk);
    chk("t1_addr_last", {bus.mem_enable, bus.mem_addr}, {1'b1, 16'h123E});
    repeat (3) nxt();
    @(negedge clk);
    chk("t1_no_early_done", bus.i_fill_done, 0);
    nxt();
    @(negedge clk);
    chk("t1_done", {bus.i_fill_done, bus.i_fill_word, bus.i_fill_data}, {1'b1, 3'd7, 16'h40B2});
    nxt();
    bus.i_miss_req = 0;
    @(negedge clk);
    chk("t1_idle", bus.busy, 0);

    // Collision after reset: I first, then D; the next collision favours D.
    do_reset();
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h0100;
    bus.d_miss_req = 1; bus.d_miss_addr = 16'h2208;
    nxt();
    @(negedge clk);
    chk("t2_i_first", bus.mem_addr, 16'h0100);
    wait_done(1'b0, "t2_i_done_seen");
    nxt();
    bus.i_miss_addr = 16'h0300;
    @(negedge clk);
    chk("t2_idle_gap", bus.busy, 0);
    nxt();
    @(negedge clk);
    chk("t2_d_second", bus.mem_addr, 16'h2200);
    wait_done(1'b1, "t2_d_done_seen");
    nxt();
    bus.d_miss_req = 0;
    nxt();
    @(negedge clk);
    chk("t2_i_after_d", bus.mem_addr, 16'h0300);
    wait_done(1'b0, "t2_i2_done_seen");
    nxt();
    bus.i_miss_req = 0;

    // Store beats a pending D miss; the D fill follows.
    bus.d_miss_req = 1; bus.d_miss_addr = 16'h5004;
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h4000; bus.d_wr_data = 16'hBEEF;
    nxt();
    @(negedge clk);
    chk("t3_write", {bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.d_wr_ack},
        {1'b1, 1'b1, 16'h4000, 16'hBEEF, 1'b1});
    nxt();
    bus.d_wr_req = 0;
    @(negedge clk);
    chk("t3_ack_single", bus.d_wr_ack, 0);
    nxt();
    @(negedge clk);
    chk("t3_fill_next", {bus.mem_wr, bus.mem_addr}, {1'b0, 16'h5000});
    wait_done(1'b1, "t3_d_done_seen");
    nxt();
    bus.d_miss_req = 0;

    // Reset in cycle 6 of a D fill; stale returns must not surface.
    bus.d_miss_req = 1; bus.d_miss_addr = 16'h6000;
    nxt();
    repeat (5) nxt();
    rst = 1'b1;
    bus.d_miss_req = 0;
    #1;
    chk("t4_rst_outputs", {bus.busy, bus.mem_enable, bus.mem_addr, bus.d_fill_valid, bus.d_fill_data},
        34'd0);
    nxt();
    nxt();
    rst = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      stale += int'(bus.mem_data_valid);
      chk("t4_no_stale_fill", bus.d_fill_valid, 0);
      nxt();
    end
    chk("t4_stale_seen", 64'(stale > 0), 64'd1);
    bus.i_miss_req = 1; bus.i_miss_addr = 16'h7772;
    nxt();
    @(negedge clk);
    chk("t4_i_after_rst", bus.mem_addr, 16'h7770);
    wait_done(1'b0, "t4_i_done_seen");
    nxt();
    bus.i_miss_req = 0;

    // D request withdrawn in cycle 3: the fill still completes in full.
    bus.d_miss_req = 1; bus.d_miss_addr = 16'h8888;
    nxt();
    nxt();
    nxt();
    bus.d_miss_req = 0;
    words = 0; dones = 0;
    for (int n = 0; n < 30 && dones == 0; n++) begin
      @(negedge clk);
      words += int'(bus.d_fill_valid);
      dones += int'(bus.d_fill_done);
    end
    nxt();
    @(negedge clk);
    chk("t5_busy_fall", bus.busy, 0);
    repeat (3) begin
      nxt();
      @(negedge clk);
      dones += int'(bus.d_fill_done);
    end
    chk("t5_words", 64'(words), 64'd8);
    chk("t5_dones", 64'(dones), 64'd1);
    nxt();

    // Random traffic: requesters hold until their done/ack, then release.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      si = bus.i_fill_done;
      sd = bus.d_fill_done;
      sa = bus.d_wr_ack;
      nxt();
      if (bus.i_miss_req) begin
        if (si) bus.i_miss_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.i_miss_req = 1;
        bus.i_miss_addr = 16'($urandom);
      end
      if (bus.d_miss_req) begin
        if (sd) bus.d_miss_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.d_miss_req = 1;
        bus.d_miss_addr = 16'($urandom);
      end
      if (bus.d_wr_req) begin
        if (sa) bus.d_wr_req = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        bus.d_wr_req = 1;
        bus.d_wr_addr = 16'($urandom);
        bus.d_wr_data = 16'($urandom);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
